// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-read-port integer register file. It has write-to-read bypass and a
//   per-register busy scoreboard for hazard detection. Decode drives the read
//   addresses and the claims. Writeback drives the write port.
//
//   After reset, a clear sequence zeroes one entry per cycle. The storage
//   therefore needs no reset and can map onto block RAM. Each read port owns
//   a private copy of the array. Every write goes to all copies, so each copy
//   needs only one read port and one write port.
//
// Ports
//   i_clk              clock; all state changes on the rising edge
//   i_reset            synchronous, active-high reset
//   i_read_register    NRD packed read addresses, port k at [k*AW +: AW]
//   o_read_data        NRD packed read results (1-cycle latency), port k at [k*XLEN +: XLEN]
//   o_busy             busy flag of each read port's address, post-edge view
//   i_we               write enable
//   i_write_register   write address
//   i_write_data       write data
//   i_claim            mark i_claim_register busy
//   i_claim_register   register to claim
//   o_ready            high once the clear sequence has finished
module register_file_mp #(
  parameter int  XLEN     = 32,
  parameter int  NREGS    = 32,
  parameter int  NRD      = 2,
  parameter int  BYPASS   = 1,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NRD*AW-1:0]   i_read_register,
  output logic [NRD*XLEN-1:0] o_read_data,
  output logic [NRD-1:0]      o_busy,
  input  logic                i_we,
  input  logic [AW-1:0]       i_write_register,
  input  logic [XLEN-1:0]     i_write_data,
  input  logic                i_claim,
  input  logic [AW-1:0]       i_claim_register,
  output logic                o_ready
);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  // Source of each port's registered output. The RAM output register cannot
  // be reset. A registered selector masks it instead: it forces zero after
  // reset, during clear and for register 0, and it picks the forwarded write.
  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_BYP,
    SEL_MEM
  } sel_t;

  genvar gi;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   byp_data_q, byp_data_d;

  logic              run;
  logic              wr_allowed;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [XLEN-1:0]   mem_wdata;

  assign run        = (state_q == ST_RUN);
  assign wr_allowed = i_we && !((ZERO_REG != 0) && (i_write_register == '0));
  assign o_ready    = run;

  // ---------------------------------------------------------------------------
  // Clear / run FSM and the shared write port of all array copies
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_waddr = i_write_register;
    mem_wdata = i_write_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we = wr_allowed;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
    // The clear restarts after reset anyway. Blocking the write keeps a
    // reset cycle from touching the storage.
    if (i_reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. A claim beats a simultaneous writeback to the same
  // register: the new producer has been issued after the one that is
  // retiring. Claims and writebacks are ignored while clearing.
  // ---------------------------------------------------------------------------
  for (gi = 0; gi < NREGS; gi++) begin : g_busy
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_hardwired
      assign busy_d[gi] = 1'b0;
    end else begin : g_tracked
      logic claim_hit;
      logic write_hit;
      assign claim_hit  = i_claim && (i_claim_register == AW'(gi));
      assign write_hit  = i_we && (i_write_register == AW'(gi));
      assign busy_d[gi] = !run     ? 1'b0 :
                          claim_hit ? 1'b1 :
                          write_hit ? 1'b0 :
                                      busy_q[gi];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // One register captures the write data for forwarding. All ports share it
  // because there is only one write port.
  assign byp_data_d = i_write_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      byp_data_q <= '0;
    end else begin
      byp_data_q <= byp_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: each has a private array copy with a registered read.
  // ---------------------------------------------------------------------------
  for (gi = 0; gi < NRD; gi++) begin : g_port
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] mem [NREGS];
    logic [XLEN-1:0] mem_rd_q;
    sel_t            sel_q, sel_d;
    logic            busy_out_q, busy_out_d;

    assign ra = i_read_register[gi*AW +: AW];

    // The read happens in the same process as the write. A read of the
    // address being written therefore returns the old contents. Forwarding
    // is handled by the selector, not by the RAM.
    always_ff @(posedge i_clk) begin
      if (mem_we) begin
        mem[mem_waddr] <= mem_wdata;
      end
      mem_rd_q <= mem[ra];
    end

    always_comb begin
      sel_d = SEL_ZERO;
      if (run) begin
        if ((ZERO_REG != 0) && (ra == '0)) begin
          sel_d = SEL_ZERO;
        end else if ((BYPASS != 0) && i_we && (i_write_register == ra)) begin
          sel_d = SEL_BYP;
        end else begin
          sel_d = SEL_MEM;
        end
      end
    end

    // busy_d is already zero while clearing. It is the post-edge value, so
    // a writeback or claim in this cycle shows up immediately.
    assign busy_out_d = busy_d[ra];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        sel_q      <= SEL_ZERO;
        busy_out_q <= 1'b0;
      end else begin
        sel_q      <= sel_d;
        busy_out_q <= busy_out_d;
      end
    end

    assign o_read_data[gi*XLEN +: XLEN] = (sel_q == SEL_BYP) ? byp_data_q :
                                          (sel_q == SEL_MEM) ? mem_rd_q   :
                                                               '0;
    assign o_busy[gi] = busy_out_q;
  end

endmodule
